imem_loader: RTL and testbench

- Write-side counterpart to the read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake from a UART RX or testbench host, assembles little-endian 32-bit instruction words, and issues single-cycle word writes into instruction memory.
- Holds the CPU in reset while loading, then releases it, so programs load at run time rather than from a hex file at elaboration.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared instruction-memory constants and loader state encoding
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian 4-byte lane assembler
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_word_full,
    output logic [31:0] o_word
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic [31:0] w_word;

    // Merge the byte being accepted this cycle so the full word is visible on the 4th byte
    always_comb begin
        w_word = r_word;
        if (i_accept) begin
            w_word[{r_byte_idx, 3'b000} +: 8] = i_byte;
        end
    end

    assign o_word      = w_word;
    assign o_word_full = i_accept && (r_byte_idx == 2'd3);

    // Lane storage and byte index; the index wraps to 0 after the 4th byte
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_word     <= '0;
            r_byte_idx <= '0;
        end else if (i_accept) begin
            r_word     <= w_word;
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with CPU reset hold
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_checksum,
    output logic              o_cpu_rst_n
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W:0]    r_n;
    logic [ADDR_W-1:0]  r_word_ptr;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_checksum;
    logic               r_err;
    logic               r_cpu_rst_n;

    logic               w_in_ready;
    logic               w_mem_we;
    logic               w_busy;
    logic               w_done;
    logic               w_start_acc;
    logic               w_over;
    logic [ADDR_W:0]    w_n_start;
    logic [ADDR_W:0]    w_ptr_inc;
    logic               w_last_word;
    logic               w_accept;
    logic               w_word_full;
    logic [31:0]        w_word;

    assign w_over      = i_word_count > L_DEPTH;
    assign w_n_start   = w_over ? L_DEPTH : i_word_count;
    assign w_start_acc = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept    = w_in_ready && i_in_valid;
    assign w_ptr_inc   = {1'b0, r_word_ptr} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word = (w_ptr_inc == r_n);

    imem_loader_byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_start_acc),
        .i_accept    (w_accept),
        .i_byte      (i_in_data),
        .o_word_full (w_word_full),
        .o_word      (w_word)
    );

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_mem_we     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_done = (r_state == DONE);
                if (w_start_acc) begin
                    w_next_state = (w_n_start == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_word_full) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_mem_we     = 1'b1;
                w_busy       = 1'b1;
                w_next_state = w_last_word ? DONE : RECV;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register; rst aborts any load immediately
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // CPU is released only while the loader sits in DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_cpu_rst_n <= (w_next_state == DONE);
        end
    end

    // Load setup on start, word pointer advance and checksum accumulation after each write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n        <= '0;
            r_word_ptr <= '0;
            r_checksum <= '0;
            r_err      <= 1'b0;
        end else if (w_start_acc) begin
            r_n        <= w_n_start;
            r_word_ptr <= '0;
            r_checksum <= '0;
            r_err      <= w_over;
        end else if (r_state == WRITE) begin
            r_checksum <= r_checksum ^ r_mem_wdata;
            if (!w_last_word) begin
                r_word_ptr <= w_ptr_inc[ADDR_W-1:0];
            end
        end
    end

    // Memory address/data are captured with the 4th byte and held until the next word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_word_full) begin
            r_mem_addr  <= 32'({r_word_ptr, 2'b00});
            r_mem_wdata <= w_word;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mem_we    = w_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_err       = r_err;
    assign o_checksum  = r_checksum;
    assign o_cpu_rst_n = r_cpu_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] word_count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, mem_we, busy, done, err, cpu_rst_n;
    logic [31:0] mem_addr, mem_wdata, checksum;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        int          gap;
        int          wc;
        logic [63:0] data;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] chk;
    } load_vec_t;

    load_vec_t vecs[4];

    imem_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_word_count (word_count),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_checksum   (checksum),
        .o_cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic do_start(input int wc);
        @(negedge clk);
        start = 1'b1;
        word_count = 11'(wc);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (chk_gap) chk("gap_in_ready", {31'b0, in_ready}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        logic [31:0] exp_chk;
        logic [31:0] w;
        int bad;

        vecs[0] = '{gap: 0, wc: 2, data: 64'h002081B3_00600093, w0: 32'h00600093, w1: 32'h002081B3, chk: 32'h00408120};
        vecs[1] = '{gap: 3, wc: 2, data: 64'h002081B3_00600093, w0: 32'h00600093, w1: 32'h002081B3, chk: 32'h00408120};
        vecs[2] = '{gap: 1, wc: 1, data: 64'h00000000_12345678, w0: 32'h12345678, w1: 32'h0,        chk: 32'h12345678};
        vecs[3] = '{gap: 0, wc: 2, data: 64'h80000000_FFFFFFFF, w0: 32'hFFFFFFFF, w1: 32'h80000000, chk: 32'h7FFFFFFF};

        // reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_writes", 32'(wr_addr.size()), 32'd0);
        chk("idle_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);

        // table-driven loads
        for (int v = 0; v < 4; v++) begin
            clear_log();
            do_start(vecs[v].wc);
            chk("load_busy", {31'b0, busy}, 32'd1);
            chk("load_cpu_rst_n_low", {31'b0, cpu_rst_n}, 32'd0);
            for (int i = 0; i < vecs[v].wc * 4; i++) begin
                send_byte(vecs[v].data[i*8 +: 8], vecs[v].gap, (i % 4) != 0);
            end
            chk("last_write_we", {31'b0, mem_we}, 32'd1);
            chk("last_write_not_done", {31'b0, done}, 32'd0);
            @(posedge clk);
            #1;
            chk("load_done", {31'b0, done}, 32'd1);
            chk("load_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);
            chk("load_we_low", {31'b0, mem_we}, 32'd0);
            chk("load_err", {31'b0, err}, 32'd0);
            chk("load_checksum", checksum, vecs[v].chk);
            chk("load_nwrites", 32'(wr_addr.size()), 32'(vecs[v].wc));
            if (wr_addr.size() >= 1) begin
                chk("load_addr0", wr_addr[0], 32'h0);
                chk("load_data0", wr_data[0], vecs[v].w0);
            end
            if (vecs[v].wc == 2 && wr_addr.size() >= 2) begin
                chk("load_addr1", wr_addr[1], 32'h4);
                chk("load_data1", wr_data[1], vecs[v].w1);
            end
        end

        // zero word count
        clear_log();
        do_start(0);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_busy", {31'b0, busy}, 32'd0);
        chk("zero_err", {31'b0, err}, 32'd0);
        chk("zero_checksum", checksum, 32'd0);
        repeat (5) @(negedge clk);
        chk("zero_no_writes", 32'(wr_addr.size()), 32'd0);

        // overflow word count clamps to full depth
        clear_log();
        do_start(1025);
        chk("ovf_err", {31'b0, err}, 32'd1);
        chk("ovf_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4096; i++) begin
            send_byte(8'(i), 0, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("ovf_done", {31'b0, done}, 32'd1);
        chk("ovf_err_sticky", {31'b0, err}, 32'd1);
        chk("ovf_nwrites", 32'(wr_addr.size()), 32'd1024);
        exp_chk = '0;
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            exp_chk ^= w;
            if (k < wr_addr.size()) begin
                if (wr_addr[k] !== 32'(k*4) || wr_data[k] !== w) bad++;
            end
        end
        chk("ovf_all_words", 32'(bad), 32'd0);
        if (wr_addr.size() == 1024) chk("ovf_last_addr", wr_addr[1023], 32'hFFC);
        chk("ovf_checksum", checksum, exp_chk);

        // abort mid-load with reset, then a clean reload
        clear_log();
        do_start(2);
        send_byte(8'h93, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h60, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hB3, 0, 1'b0);
        do_reset(1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_checksum", checksum, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_nwrites", 32'(wr_addr.size()), 32'd1);
        clear_log();
        do_start(1);
        send_byte(8'h23, 0, 1'b0);
        send_byte(8'hA4, 0, 1'b0);
        send_byte(8'h64, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        @(posedge clk);
        #1;
        chk("reload_done", {31'b0, done}, 32'd1);
        chk("reload_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() >= 1) begin
            chk("reload_addr", wr_addr[0], 32'h0);
            chk("reload_data", wr_data[0], 32'h0064A423);
        end
        chk("reload_checksum", checksum, 32'h0064A423);

        // start during RECV is ignored
        clear_log();
        do_start(2);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        do_start(0);
        chk("ign_busy", {31'b0, busy}, 32'd1);
        chk("ign_in_ready", {31'b0, in_ready}, 32'd1);
        chk("ign_done", {31'b0, done}, 32'd0);
        send_byte(8'h33, 0, 1'b0);
        send_byte(8'h44, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        send_byte(8'h66, 0, 1'b0);
        send_byte(8'h77, 0, 1'b0);
        send_byte(8'h88, 0, 1'b0);
        @(posedge clk);
        #1;
        chk("ign_load_done", {31'b0, done}, 32'd1);
        chk("ign_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() >= 2) begin
            chk("ign_data0", wr_data[0], 32'h44332211);
            chk("ign_addr1", wr_addr[1], 32'h4);
            chk("ign_data1", wr_data[1], 32'h88776655);
        end

        // restart from DONE
        clear_log();
        do_start(1);
        chk("restart_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("restart_busy", {31'b0, busy}, 32'd1);
        chk("restart_done", {31'b0, done}, 32'd0);
        chk("restart_checksum", checksum, 32'd0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        send_byte(8'hCC, 0, 1'b0);
        send_byte(8'hDD, 0, 1'b0);
        @(posedge clk);
        #1;
        chk("restart_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() >= 1) begin
            chk("restart_addr", wr_addr[0], 32'h0);
            chk("restart_data", wr_data[0], 32'hDDCCBBAA);
        end
        chk("restart_final_checksum", checksum, 32'hDDCCBBAA);
        chk("restart_final_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
